// File: rtl/rob_tag_alloc_if.sv
// Bundle between the ROB tag allocator, rename and the rename map's write/invalidate ports.
// With ROB_ALLOC_STAT_EN defined, the bundle also carries the stall_cnt statistic.
`ifndef RobDepth
`define RobDepth 8
`endif

interface rob_tag_alloc_if #(
    parameter int DEPTH = `RobDepth,
    parameter int ALLOC = 2
);
    localparam int ADDR = $clog2(DEPTH);

    logic [ALLOC-1:0]      req_;
    logic [ALLOC-1:0]      grant;
    logic [ALLOC*ADDR-1:0] tag;
    logic                  com_;
    logic                  inve_;
    logic [ADDR-1:0]       invaddr;
    logic                  flush_in_;
    logic                  flush_;
    logic                  empty;
    logic                  full;
    logic [ADDR:0]         count;
`ifdef ROB_ALLOC_STAT_EN
    logic [31:0]           stall_cnt;

    modport master (
        input  req_, com_, flush_in_,
        output grant, tag, inve_, invaddr, flush_, empty, full, count, stall_cnt
    );
    modport slave (
        output req_, com_, flush_in_,
        input  grant, tag, inve_, invaddr, flush_, empty, full, count, stall_cnt
    );
`else
    modport master (
        input  req_, com_, flush_in_,
        output grant, tag, inve_, invaddr, flush_, empty, full, count
    );
    modport slave (
        output req_, com_, flush_in_,
        input  grant, tag, inve_, invaddr, flush_, empty, full, count
    );
`endif
endinterface

// File: rtl/rob_tag_alloc.sv
// In-order ROB tag allocator/retirer: up to ALLOC tags per cycle, oldest-first retire, flush.
// Optional macro ROB_ALLOC_STAT_EN adds a saturating allocation-stall counter (stall_cnt).
`ifndef RobDepth
`define RobDepth 8
`endif

module rob_tag_alloc #(
    parameter int DEPTH = `RobDepth,
    parameter int ALLOC = 2
) (
    input  logic           clk,
    input  logic           reset_,
    rob_tag_alloc_if.master bus
);
    localparam int ADDR = $clog2(DEPTH);
    localparam int CW   = ADDR + 1;

    logic [ADDR-1:0]       head_q, head_d;
    logic [ADDR-1:0]       tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  flush_q;

    logic [CW-1:0]         free;
    logic [CW-1:0]         n_alloc;
    logic [ALLOC-1:0]      grant;
    logic [ALLOC*ADDR-1:0] tag;
    logic                  prev;
    logic                  retire;

    // Free slots come from the pre-update count, so a slot retired this cycle is not reusable yet.
    assign free = CW'(DEPTH) - count_q;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        grant   = '0;
        prev    = 1'b1;
        n_alloc = '0;
        tag     = '0;
        for (int i = 0; i < ALLOC; i++) begin
            grant[i] = prev && !bus.req_[i] && (free > CW'(i)) && bus.flush_in_ && reset_;
            prev     = grant[i];
            n_alloc  = n_alloc + CW'(grant[i]);
            tag[i*ADDR +: ADDR] = tail_q + ADDR'(i);
        end
    end

    assign retire = !bus.com_ && (count_q != '0) && bus.flush_in_ && reset_;

    always_comb begin
        head_d  = head_q + ADDR'(retire);
        tail_d  = tail_q + n_alloc[ADDR-1:0];
        count_d = count_q + n_alloc - CW'(retire);
        if (!bus.flush_in_) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            flush_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            flush_q <= bus.flush_in_;
        end
    end

    assign bus.grant   = grant;
    assign bus.tag     = tag;
    assign bus.inve_   = !retire;
    assign bus.invaddr = head_q;
    assign bus.flush_  = flush_q;
    assign bus.empty   = (count_q == '0);
    assign bus.full    = (count_q == CW'(DEPTH));
    assign bus.count   = count_q;

`ifdef ROB_ALLOC_STAT_EN
    logic [31:0] stall_q, stall_d;

    // Counts cycles where lane 0 wants a tag but cannot get one; flush cycles never count.
    always_comb begin
        stall_d = stall_q;
        if (!bus.flush_in_) begin
            stall_d = '0;
        end else if (!bus.req_[0] && !grant[0] && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.stall_cnt = stall_q;
`endif
endmodule
